// File: rtl/decoder_rr_scheduler.sv
// decoder_rr_scheduler: round-robin owner of one 4-to-16 decoder select path; optional hold timeout via DRS_HOLD_TIMEOUT_EN
module decoder_rr_scheduler #(
   parameter int N_REQ      = 16,
   parameter int GAP_CYCLES = 1
`ifdef DRS_HOLD_TIMEOUT_EN
   ,parameter int MAX_HOLD  = 64
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [3:0]       D,
   output logic             En,
   output logic [0:15]      grant,
   output logic             busy,
   output logic             timeout
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
   state_t      state;
   logic [3:0]  ptr;
   logic [3:0]  pick;
   logic [0:15] pick_oh;
   logic [1:0]  gap;
   logic        release_now;
   logic        force_rel;
`ifdef DRS_HOLD_TIMEOUT_EN
   logic [7:0]  hold;
   assign force_rel = (hold == 8'(MAX_HOLD - 1));
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif
   // Owner gives up the path on a done strobe or by dropping its own request
   assign release_now = done | ~req[D];
   // Circular first-set search starting at ptr; lowest offset wins
   always_comb begin
      pick = '0;
      for (int k = 15; k >= 0; k--)
         if (req[ptr + 4'(k)]) pick = ptr + 4'(k);
   end
   // One-hot image of the chosen index in decoder Y[0:15] order
   always_comb begin
      pick_oh = '0;
      for (int i = 0; i < 16; i++) pick_oh[i] = (pick == 4'(i));
   end
   // Scheduler FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         D     <= '0;
         En    <= 1'b0;
         grant <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         gap   <= '0;
`ifdef DRS_HOLD_TIMEOUT_EN
         hold    <= '0;
         timeout <= 1'b0;
`endif
      end else begin
`ifdef DRS_HOLD_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            IDLE: if (|req) begin
               D     <= pick;
               En    <= 1'b1;
               grant <= pick_oh;
               busy  <= 1'b1;
               state <= GRANT;
`ifdef DRS_HOLD_TIMEOUT_EN
               hold  <= '0;
`endif
            end
            GRANT: begin
               if (release_now | force_rel) begin
                  En    <= 1'b0;
                  grant <= '0;
                  ptr   <= D + 4'd1;
                  gap   <= '0;
                  state <= GAP;
               end
`ifdef DRS_HOLD_TIMEOUT_EN
               timeout <= force_rel & ~release_now;
               hold    <= hold + 8'd1;
`endif
            end
            GAP: if (gap == 2'(GAP_CYCLES - 1)) begin
               gap   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end else begin
               gap <= gap + 2'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// tb_decoder_rr_scheduler: directed self-checking bench for decoder_rr_scheduler (GAP_CYCLES=1)
module tb_decoder_rr_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req;
   logic        done;
   logic [3:0]  D;
   logic        En;
   logic [0:15] grant;
   logic        busy;
   logic        timeout;
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   decoder_rr_scheduler #(
      .N_REQ(16),
      .GAP_CYCLES(1)
`ifdef DRS_HOLD_TIMEOUT_EN
      ,.MAX_HOLD(4)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .done(done),
      .D(D),
      .En(En),
      .grant(grant),
      .busy(busy),
      .timeout(timeout)
   );

   function automatic logic [0:15] oh(input logic [3:0] d);
      logic [0:15] g;
      g    = '0;
      g[d] = 1'b1;
      return g;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] d, input logic en, input logic b, input logic t);
      chk({tag, ".D"}, 32'(D), 32'(d));
      chk({tag, ".En"}, 32'(En), 32'(en));
      chk({tag, ".grant"}, 32'(grant), en ? 32'(oh(d)) : 32'h0);
      chk({tag, ".busy"}, 32'(busy), 32'(b));
      chk({tag, ".timeout"}, 32'(timeout), 32'(t));
   endtask

   task automatic grant_cycle(input string tag, input logic [3:0] d);
      step();
      chk_all({tag, "_grant"}, d, 1'b1, 1'b1, 1'b0);
      done = 1'b1;
      step();
      chk_all({tag, "_gap"}, d, 1'b0, 1'b1, 1'b0);
      done = 1'b0;
      step();
      chk_all({tag, "_idle"}, d, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      repeat (2) step();
      chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_all("idle", 4'd0, 1'b0, 1'b0, 1'b0);
      done = 1'b1;
      step();
      chk_all("done_in_idle", 4'd0, 1'b0, 1'b0, 1'b0);
      done = 1'b0;
      req  = 16'h0020;
      step();
      chk_all("single_grant", 4'd5, 1'b1, 1'b1, 1'b0);
      done = 1'b1;
      req  = 16'h0000;
      step();
      chk_all("single_rel", 4'd5, 1'b0, 1'b1, 1'b0);
      done = 1'b0;
      step();
      chk_all("single_idle", 4'd5, 1'b0, 1'b0, 1'b0);
      req = 16'hFFFF;
      step();
      chk_all("mid_grant", 4'd6, 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_reset", 4'd0, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("reset_held", 4'd0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) grant_cycle("rot", 4'(i));
      for (int i = 1; i < 14; i++) grant_cycle("rot2", 4'(i));
      req = 16'h0208;
      grant_cycle("wrap_a", 4'd3);
      grant_cycle("wrap_b", 4'd9);
      req = 16'h0080;
      step();
      chk_all("wd_grant", 4'd7, 1'b1, 1'b1, 1'b0);
      req  = 16'h0110;
      done = 1'b1;
      step();
      chk_all("wd_rel", 4'd7, 1'b0, 1'b1, 1'b0);
      done = 1'b0;
      step();
      chk_all("wd_idle", 4'd7, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("wd_next", 4'd8, 1'b1, 1'b1, 1'b0);
      req = 16'h0131;
      step();
      chk_all("other_bits", 4'd8, 1'b1, 1'b1, 1'b0);
      req = 16'h0031;
      step();
      chk_all("withdraw_rel", 4'd8, 1'b0, 1'b1, 1'b0);
      req = 16'h0004;
      step();
      chk_all("withdraw_idle", 4'd8, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("hold_grant", 4'd2, 1'b1, 1'b1, 1'b0);
`ifdef DRS_HOLD_TIMEOUT_EN
      repeat (3) begin
         step();
         chk_all("hold", 4'd2, 1'b1, 1'b1, 1'b0);
      end
      step();
      chk_all("timeout_rel", 4'd2, 1'b0, 1'b1, 1'b1);
      step();
      chk_all("timeout_idle", 4'd2, 1'b0, 1'b0, 1'b0);
      step();
      chk_all("regrant", 4'd2, 1'b1, 1'b1, 1'b0);
`else
      repeat (6) begin
         step();
         chk_all("hold", 4'd2, 1'b1, 1'b1, 1'b0);
      end
`endif
      done = 1'b1;
      step();
      chk_all("final_rel", 4'd2, 1'b0, 1'b1, 1'b0);
      done = 1'b0;
      req  = 16'h0000;
      step();
      chk_all("final_idle", 4'd2, 1'b0, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
